// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer: carries the decoded control word through EX/MEM/WB,
// stalls issue during multi-cycle shifts and selects EX operand forwarding.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_seq #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned SHIFT_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic              id_reg_write,
    input  logic              id_shift,
    input  logic              id_imm_sel,
    input  logic [3:0]        id_aluop,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              ex_valid,
    output logic [3:0]        ex_aluop,
    output logic              ex_imm_sel,
    output logic              ex_shift,
    output logic              ex_done,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned FWD_W = 2;

    localparam logic [CNT_W-1:0] SHIFT_CNT = CNT_W'(SHIFT_LAT - 1);
    localparam logic [FWD_W-1:0] FWD_RF    = FWD_W'(0);
    localparam logic [FWD_W-1:0] FWD_MEM   = FWD_W'(1);
    localparam logic [FWD_W-1:0] FWD_WB    = FWD_W'(2);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              shift;
        logic              imm_sel;
        logic [OP_W-1:0]   aluop;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [CNT_W-1:0]  cnt;
    } ex_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
    } ret_t;

    ex_t  ex_q;
    ret_t mem_q;
    ret_t wb_q;
    logic wb_we_q;

    logic ex_hold;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // Shift holds EX until its countdown reaches zero
    assign ex_hold  = ex_q.valid & ex_q.shift & (ex_q.cnt != '0);
    assign id_ready = ~ex_hold;
    assign ex_done  = ex_q.valid & ~ex_hold;

    assign ex_valid   = ex_q.valid;
    assign ex_aluop   = ex_q.valid ? ex_q.aluop : OP_W'(0);
    assign ex_imm_sel = ex_q.valid & ex_q.imm_sel;
    assign ex_shift   = ex_q.valid & ex_q.shift;

    // EX stage register: flush > hold > issue > bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q.valid <= 1'b0;
            ex_q.cnt   <= '0;
        end else if (ex_hold) begin
            ex_q.cnt <= ex_q.cnt - CNT_W'(1);
        end else if (id_valid) begin
            ex_q.valid     <= 1'b1;
            ex_q.reg_write <= id_reg_write;
            ex_q.shift     <= id_shift;
            ex_q.imm_sel   <= id_imm_sel;
            ex_q.aluop     <= id_aluop;
            ex_q.rs1       <= id_rs1;
            ex_q.rs2       <= id_rs2;
            ex_q.rd        <= id_rd;
            ex_q.cnt       <= id_shift ? SHIFT_CNT : CNT_W'(0);
        end else begin
            ex_q.valid <= 1'b0;
        end
    end

    // MEM and WB never stall; bubbles carry zeroed fields so wb_rd reads 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            wb_q    <= '0;
            wb_we_q <= 1'b0;
        end else begin
            if (ex_done & ~flush) begin
                mem_q.valid     <= 1'b1;
                mem_q.reg_write <= ex_q.reg_write;
                mem_q.rd        <= ex_q.rd;
            end else begin
                mem_q <= '0;
            end
            wb_q    <= mem_q;
            wb_we_q <= mem_q.valid & mem_q.reg_write & (mem_q.rd != '0);
        end
    end

    assign wb_reg_write = wb_we_q;
    assign wb_rd        = wb_q.rd;

    assign mem_fwd_ok = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0);
    assign wb_fwd_ok  = wb_q.valid & wb_q.reg_write & (wb_q.rd != '0);

    // Operand forwarding, younger (MEM) result wins over WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_q.valid) begin
            if (mem_fwd_ok && (mem_q.rd == ex_q.rs1)) begin
                fwd_a = FWD_MEM;
            end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs1)) begin
                fwd_a = FWD_WB;
            end
            if (!ex_q.imm_sel) begin
                if (mem_fwd_ok && (mem_q.rd == ex_q.rs2)) begin
                    fwd_b = FWD_MEM;
                end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs2)) begin
                    fwd_b = FWD_WB;
                end
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (wb_q.valid) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (id_valid & ~id_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_ctrl_seq.md
Name: pipe_ctrl_seq

Overview:
- Pipeline control sequencer for the 5-stage core.
- Takes the decoded ID-stage control word (reg_write, shift, imm_sel, ALUop) and register addresses, then carries them through EX/MEM/WB.
- Holds issue while the iterative shifter occupies EX, generates bubbles, and computes operand-forwarding selects for the EX-stage ALU.
- Owns the write-back enable to the register file.

Parameters:
- REG_AW, 5: register address width.
- SHIFT_LAT, 3: EX-stage cycles taken by a shift instruction; legal range 1..15. A value of 1 means no hold.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a decoded instruction.
- id_ready  out  1  sequencer accepts the ID instruction this cycle.
- id_reg_write  in  1  decoded write enable.
- id_shift  in  1  decoded shift flag (multi-cycle EX).
- id_imm_sel  in  1  operand B comes from the immediate.
- id_aluop  in  4  decoded ALU operation.
- id_rs1, id_rs2, id_rd  in  REG_AW each  source and destination registers.
- flush  in  1  kill the EX-stage instruction and the instruction issuing this cycle.
- ex_valid  out  1  EX holds a live instruction.
- ex_aluop  out  4  ALU operation for EX; 0 when EX is invalid.
- ex_imm_sel  out  1  EX immediate select; 0 when EX is invalid.
- ex_shift  out  1  EX shift flag; 0 when EX is invalid.
- ex_done  out  1  EX result is final this cycle and the instruction advances next edge.
- fwd_a, fwd_b  out  2  operand source: 00 = register file, 01 = MEM result, 10 = WB result.
- wb_reg_write  out  1  register-file write enable.
- wb_rd  out  REG_AW  register-file write address.

Behaviour:
Stage state:
- EX register holds: valid, reg_write, shift, imm_sel, aluop, rs1, rs2, rd, plus a 4-bit countdown cnt.
- MEM and WB registers each hold: valid, reg_write, rd.

Hold and issue:
- ex_hold = ex_valid & ex_shift & (cnt != 0).
- id_ready = ~ex_hold.
- ex_done = ex_valid & ~ex_hold.

EX register update, in priority order:
1. flush: valid <= 0, cnt <= 0. The ID instruction is consumed (id_ready still follows ~ex_hold) and discarded.
2. ex_hold: EX retains its contents, cnt <= cnt - 1.
3. id_valid & id_ready: load the ID fields. cnt <= SHIFT_LAT - 1 if id_shift, else 0.
4. Otherwise: valid <= 0.

MEM update:
- MEM <= EX when ex_done & ~flush.
- Otherwise MEM <= bubble (valid = 0).
- A flush during a hold kills the shift; it does not reach MEM.

WB update:
- WB <= MEM every cycle. MEM and WB never stall.

Write-back:
- wb_reg_write = wb_valid & wb_reg_write_q & (wb_rd != 0). Register 0 is never written.
- wb_rd is the registered rd; it is 0 when WB is invalid.

Forwarding (combinational from registered state):
- fwd_a = 01 if mem_valid & mem_reg_write & mem_rd != 0 & mem_rd == ex_rs1.
- Else fwd_a = 10 if the same condition holds for WB.
- Else fwd_a = 00.
- MEM has priority over WB.
- fwd_b uses the same rule with ex_rs2, but is forced to 00 when ex_imm_sel = 1.
- fwd_a and fwd_b are both 00 when EX is invalid.

Reset (asynchronous, active-high):
- All valids 0, cnt 0, all stored fields 0.
- Outputs: ex_* = 0, fwd_* = 00, wb_reg_write = 0, wb_rd = 0, ex_done = 0.
- id_ready = 1.
- Reset asserted mid-shift aborts the shift with no write-back.

Simultaneous events:
- flush with ex_hold: flush wins.
- Back-to-back shifts: the second shift loads on the cycle the first reaches ex_done, with no dead cycle.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, add outputs perf_retired (32 bits) and perf_stall (32 bits), both reset to 0:
  - perf_retired increments when wb_valid.
  - perf_stall increments on each cycle where id_valid & ~id_ready.
  - Both counters wrap modulo 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-stream with a shift at cnt=1 -> all outputs 0 immediately, id_ready=1, and no wb_reg_write after release.
- ALU chain: issue rd=3 (aluop 0), then rs1=3 next cycle -> fwd_a=01 in that cycle. Issue rs2=3 one cycle later -> fwd_b=10.
- Immediate and r0: EX with imm_sel=1 and rs2 matching MEM rd -> fwd_b=00. Instruction with rd=0 -> wb_reg_write stays 0, and no forwarding occurs from it.
- Shift latency with SHIFT_LAT=3: shift issued at cycle t -> id_ready=0 for t+1 and t+2, ex_done at t+3. MEM shows bubbles at t+2 and t+3, and the shift is in MEM at t+4.
- Flush during hold: flush at the second hold cycle -> ex_valid=0 next cycle, the shift never reaches WB, and id_ready=1.
- PIPE_CTRL_PERF_EN: 4 ALU instructions plus 1 shift (SHIFT_LAT=3) with id_valid held high -> perf_retired=5 and perf_stall=2 after drain.
